hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised RAW-hazard scoreboard for the in-order pipeline. It sits in decode and consumes the per-instruction register identifiers (Rs/Rt sources, Rd destination, each with a valid bit) produced by the decode-side register identifier logic. Internally it holds a DEPTH-entry shift pipeline that mirrors the in-flight destination writes of older instructions. It asserts `stall` when a decoding instruction reads a register that is still pending, and optionally produces forwarding selects instead of stalling.

## Interface
- `REG_BITS`, default 3: register index width; the register file has 2^REG_BITS entries.
- `DEPTH`, default 3: number of stages between issue and register-file write visibility (EX, MEM, WB).
- `CW`, default `$clog2(DEPTH+1)`: width of the count and select fields. Derived; not overridden.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  a real instruction is present in decode.
- `rs`, `rt`  in  REG_BITS each  source register indices.
- `rs_valid`, `rt_valid`  in  1 each  the corresponding source is actually read.
- `rd`  in  REG_BITS  destination register index (7 for JAL/JALR).
- `rd_valid`  in  1  the instruction writes `rd`.
- `id_is_load`  in  1  the instruction is LD; its data is produced late.
- `flush`  in  1  squash all in-flight entries (taken branch or jump redirect).
- `stall`  out  1  hold decode and insert a bubble this cycle.
- `pending_cnt`  out  CW  number of valid in-flight entries.
- `fwd_rs_sel`, `fwd_rt_sel`  out  CW each  present only with HAZ_FWD_EN. 0 selects the register file; k selects the result of stage k-1.

## Operation
- **Entry contents.** Entry i, for i = 0..DEPTH-1, is {v, rd, ld}. Entry 0 is the youngest.
- **Per-cycle update.**
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= {id_valid & rd_valid & ~stall, rd, id_is_load}.
  - When an instruction issues without writing a register, or when a bubble is inserted, entry 0 gets v = 0.
  - Entry DEPTH-1 falls off the end. Its write is visible in the register file from the next cycle.
- **Match.** match_s[i] = entry[i].v & rs_valid & (rs == entry[i].rd). match_t[i] is the same with rt.
  - Every register is tracked, including R0; there is no hardwired zero register.
  - The decoding instruction's own `rd` is never compared against its own `rs`/`rt`. STU, SLBI and similar do not self-stall.
- **Stall without HAZ_FWD_EN.** stall = id_valid & ~flush & OR over i of (match_s[i] | match_t[i]).
- **Flush.**
  - All entries go to v = 0 on the next edge.
  - `stall` is 0 during the flush cycle.
  - Nothing is inserted during the flush cycle; flush wins over insertion.
- **Reset.** When `rst_n` = 0 at a clock edge, all entries go to v = 0. This applies mid-operation: any in-flight state is discarded.
- **pending_cnt.** Population count of entry[*].v. Range 0..DEPTH; no wrap.

## Timing
- Entries are registered.
- `stall`, `pending_cnt` and `fwd_*_sel` are combinational from the entries and the current decode inputs. They are valid in the same cycle and have no added latency.
- While `stall` = 1, upstream holds the decode inputs stable. The block re-evaluates every cycle.
- **Stall length, no forwarding.** A consumer that issues n cycles after its producer (n ≥ 1) stalls max(0, DEPTH − n + 1) cycles.
- **Outputs after reset.** With all entries invalid: stall = 0, pending_cnt = 0, fwd_*_sel = 0.
- **Reset and flush together.** Reset has priority over flush; the resulting state is the same.

## Configuration
- Macro: `HAZ_FWD_EN`.
- **Defined.**
  - `fwd_rs_sel` / `fwd_rt_sel` exist and are driven.
  - For each source, find the lowest i with a match (the youngest producer). The select is i+1, or 0 if nothing matches.
  - stall = id_valid & ~flush & ((match_s[0] | match_t[0]) & entry[0].ld). This is the load-use case only, and it lasts exactly one cycle.
  - When stall = 1, the selects are don't-care.
- **Not defined.**
  - The select ports are absent.
  - The stall rule in Operation applies.

## Test plan
1. **Reset.** Assert rst_n = 0 for 2 cycles with id_valid = 1 and garbage inputs → stall = 0, pending_cnt = 0. First cycle after release → pending_cnt = 0.
2. **Back-to-back RAW, no forwarding, DEPTH = 3.** ADD r1 ← r2,r3, then ADD r4 ← r1,r5 → stall = 1 for exactly 3 cycles, consumer issues on the 4th cycle. pending_cnt sequence: 1, 1, 1, 0, 1.
3. **Gap of one independent instruction.** Producer r1, then XOR r6, then consumer reading r1 → 2 stall cycles. A JAL producer (rd = 7) followed by JR r7 → 3 stall cycles.
4. **Flush mid-stall.** Raise flush on the 2nd stall cycle of scenario 2 → stall = 0 in that cycle, pending_cnt = 0 next cycle, consumer issues next cycle.
5. **No false hazard.** STU r2 (rs = rd = 2) alone → no stall. Source with rs_valid = 0 and rs equal to a pending rd → no stall. Back-to-back writes to r3 → pending_cnt = 2.
6. **HAZ_FWD_EN.**
   - ADD r1, then SUB reading r1 → no stall, fwd_rs_sel = 1.
   - ADD r1, then XOR r6, then consumer reading r1 → fwd_rs_sel = 2.
   - LD r1, then ADD reading r1 as rt → stall for 1 cycle, then fwd_rt_sel = 2.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : RAW-hazard scoreboard for the in-order pipeline decode stage.
//             A DEPTH-entry shift pipeline mirrors the destination writes of
//             older in-flight instructions. Decode stalls while it reads a
//             register that is still pending. When forwarding is enabled it
//             returns forwarding selects instead, and stalls only on a
//             load-use.
//  Ports    : clk, rst_n (sync, active-low)
//             id_valid, rs/rs_valid, rt/rt_valid, rd/rd_valid, id_is_load
//                         - decode-side register identifiers
//             flush       - squash every in-flight entry
//             stall       - hold decode and insert a bubble this cycle
//             pending_cnt - number of valid in-flight entries
//             fwd_rs_sel, fwd_rt_sel (HAZ_FWD_EN only)
//                         - 0 selects the register file, k selects the
//                           result of stage k-1
//  Config   : define HAZ_FWD_EN to enable forwarding selects
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_BITS = 3,
  parameter int DEPTH    = 3,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] rs,
  input  logic                rs_valid,
  input  logic [REG_BITS-1:0] rt,
  input  logic                rt_valid,
  input  logic [REG_BITS-1:0] rd,
  input  logic                rd_valid,
  input  logic                id_is_load,
  input  logic                flush,
  output logic                stall,
`ifdef HAZ_FWD_EN
  output logic [CW-1:0]       fwd_rs_sel,
  output logic [CW-1:0]       fwd_rt_sel,
`endif
  output logic [CW-1:0]       pending_cnt
);

  // Entry 0 is the youngest in-flight instruction.
  logic [DEPTH-1:0]    r_v;
  logic [REG_BITS-1:0] r_rd [DEPTH];
`ifdef HAZ_FWD_EN
  logic [DEPTH-1:0]    r_ld;
`else
  // Load timing only matters when forwarding is enabled.
  logic                w_unused;
  assign w_unused = id_is_load;
`endif

  logic [DEPTH-1:0] w_match_s;
  logic [DEPTH-1:0] w_match_t;
  logic             w_insert;

  // A stalled instruction has not issued, so it enters as a bubble.
  assign w_insert = id_valid & rd_valid & ~stall;

  // --------------------------------------------------------------------------
  // Entry pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i] <= '0;
      end
`ifdef HAZ_FWD_EN
      r_ld <= '0;
`endif
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_v[i]  <= r_v[i-1];
        r_rd[i] <= r_rd[i-1];
`ifdef HAZ_FWD_EN
        r_ld[i] <= r_ld[i-1];
`endif
      end
      r_v[0]  <= w_insert;
      r_rd[0] <= rd;
`ifdef HAZ_FWD_EN
      r_ld[0] <= id_is_load;
`endif
      // Flush overrides both the shift and the insertion.
      if (flush) begin
        r_v <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Source match against every in-flight destination (R0 included)
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign w_match_s[g] = r_v[g] & rs_valid & (rs == r_rd[g]);
      assign w_match_t[g] = r_v[g] & rt_valid & (rt == r_rd[g]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Occupancy
  // --------------------------------------------------------------------------
  always_comb begin
    pending_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_cnt = pending_cnt + CW'(r_v[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Stall / forwarding
  // --------------------------------------------------------------------------
`ifdef HAZ_FWD_EN
  // Only a load in the youngest slot cannot be forwarded in time.
  assign stall = id_valid & ~flush & (w_match_s[0] | w_match_t[0]) & r_ld[0];

  // Walk oldest to youngest so the youngest producer wins.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match_s[i]) begin
        fwd_rs_sel = CW'(i + 1);
      end
      if (w_match_t[i]) begin
        fwd_rt_sel = CW'(i + 1);
      end
    end
  end
`else
  assign stall = id_valid & ~flush & (|(w_match_s | w_match_t));
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Purpose  : Directed self-checking bench for hazard_scoreboard with the
//             default parameters (REG_BITS = 3, DEPTH = 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int REG_BITS = 3;
  localparam int DEPTH    = 3;
  localparam int CW       = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [REG_BITS-1:0] rs;
  logic                rs_valid;
  logic [REG_BITS-1:0] rt;
  logic                rt_valid;
  logic [REG_BITS-1:0] rd;
  logic                rd_valid;
  logic                id_is_load;
  logic                flush;
  logic                stall;
  logic [CW-1:0]       pending_cnt;
`ifdef HAZ_FWD_EN
  logic [CW-1:0]       fwd_rs_sel;
  logic [CW-1:0]       fwd_rt_sel;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .REG_BITS(REG_BITS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .rs         (rs),
    .rs_valid   (rs_valid),
    .rt         (rt),
    .rt_valid   (rt_valid),
    .rd         (rd),
    .rd_valid   (rd_valid),
    .id_is_load (id_is_load),
    .flush      (flush),
    .stall      (stall),
`ifdef HAZ_FWD_EN
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
`endif
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one decode slot, then let the combinational outputs settle.
  task automatic drive(input logic v,
                       input logic [REG_BITS-1:0] s, input logic sv,
                       input logic [REG_BITS-1:0] t, input logic tv,
                       input logic [REG_BITS-1:0] d, input logic dv,
                       input logic ld);
    id_valid   = v;
    rs         = s;
    rs_valid   = sv;
    rt         = t;
    rt_valid   = tv;
    rd         = d;
    rd_valid   = dv;
    id_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string tag);
    idle();
    repeat (DEPTH) step();
    chk(tag, 32'(pending_cnt), 32'd0);
  endtask

  // Count stall cycles of the instruction currently held in decode.
  task automatic count_stalls(output int n);
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      n++;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    flush = 1'b0;
    rst_n = 1'b0;

    // ---------------- Reset with garbage in decode ----------------
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1);
    step();
    chk("rst1_stall", 32'(stall), 32'd0);
    chk("rst1_pend",  32'(pending_cnt), 32'd0);
    step();
    chk("rst2_stall", 32'(stall), 32'd0);
    chk("rst2_pend",  32'(pending_cnt), 32'd0);
    rst_n = 1'b1;
    idle();
    step();
    chk("rel_pend", 32'(pending_cnt), 32'd0);

`ifndef HAZ_FWD_EN
    // ---------------- Back-to-back RAW ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    chk("b2b_prod_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("b2b_s1", 32'(stall), 32'd1);
    chk("b2b_p1", 32'(pending_cnt), 32'd1);
    step();
    chk("b2b_s2", 32'(stall), 32'd1);
    chk("b2b_p2", 32'(pending_cnt), 32'd1);
    step();
    chk("b2b_s3", 32'(stall), 32'd1);
    chk("b2b_p3", 32'(pending_cnt), 32'd1);
    step();
    chk("b2b_s4", 32'(stall), 32'd0);
    chk("b2b_p4", 32'(pending_cnt), 32'd0);
    step();
    idle();
    chk("b2b_p5", 32'(pending_cnt), 32'd1);
    drain("b2b_drain");

    // ---------------- One independent instruction in between ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0);
    chk("gap_xor_stall", 32'(stall), 32'd0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    count_stalls(n);
    chk("gap_stalls", 32'(n), 32'd2);
    step();
    drain("gap_drain");

    // ---------------- JAL then JR r7 ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    count_stalls(n);
    chk("jal_jr_stalls", 32'(n), 32'd3);
    step();
    drain("jal_drain");

    // ---------------- R0 is tracked, rt-only match ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd3, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
    count_stalls(n);
    chk("r0_rt_stalls", 32'(n), 32'd3);
    step();
    drain("r0_drain");

    // ---------------- Load without forwarding stalls like any producer ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    count_stalls(n);
    chk("ld_stalls", 32'(n), 32'd3);
    step();
    drain("ld_drain");

    // ---------------- Flush mid-stall ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("fl_s1", 32'(stall), 32'd1);
    step();
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_pend_during", 32'(pending_cnt), 32'd1);
    step();
    flush = 1'b0;
    #1;
    chk("fl_pend_after", 32'(pending_cnt), 32'd0);
    chk("fl_stall_after", 32'(stall), 32'd0);
    step();
    idle();
    chk("fl_issued", 32'(pending_cnt), 32'd1);
    drain("fl_drain");

    // ---------------- id_valid = 0 masks stall and insertion ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    step();
    drive(1'b0, 3'd5, 1'b1, 3'd5, 1'b1, 3'd6, 1'b1, 1'b0);
    chk("nv_stall", 32'(stall), 32'd0);
    step();
    idle();
    chk("nv_pend", 32'(pending_cnt), 32'd1);
    drain("nv_drain");
`else
    // ---------------- Forwarding: distance 1 ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0);
    chk("f1_stall", 32'(stall), 32'd0);
    chk("f1_rs", 32'(fwd_rs_sel), 32'd1);
    chk("f1_rt", 32'(fwd_rt_sel), 32'd0);
    step();
    drain("f1_drain");

    // ---------------- Forwarding: distance 2 ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd6, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("f2_stall", 32'(stall), 32'd0);
    chk("f2_rs", 32'(fwd_rs_sel), 32'd2);
    chk("f2_rt", 32'(fwd_rt_sel), 32'd1);
    step();
    drain("f2_drain");

    // ---------------- Load-use ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    step();
    drive(1'b1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    chk("lu_s1", 32'(stall), 32'd1);
    step();
    chk("lu_s2", 32'(stall), 32'd0);
    chk("lu_rt", 32'(fwd_rt_sel), 32'd2);
    step();
    drain("lu_drain");

    // ---------------- Youngest producer wins ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    chk("yw_rs", 32'(fwd_rs_sel), 32'd1);
    step();
    drain("yw_drain");
`endif

    // ---------------- No false hazard ----------------
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0);
    chk("stu_self", 32'(stall), 32'd0);
    step();
    drive(1'b1, 3'd2, 1'b0, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0);
    chk("rsv0_stall", 32'(stall), 32'd0);
    step();
    drain("nf_drain");
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
    chk("ww_stall", 32'(stall), 32'd0);
    step();
    idle();
    chk("ww_pend", 32'(pending_cnt), 32'd2);
    drain("ww_drain");

    // ---------------- Full occupancy, then reset mid-operation ----------------
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    step();
    idle();
    chk("full_pend", 32'(pending_cnt), 32'd3);
    rst_n = 1'b0;
    flush = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    step();
    chk("mid_rst_pend", 32'(pending_cnt), 32'd0);
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b1, 3'd4, 1'b1, 3'd2, 1'b1, 3'd6, 1'b1, 1'b0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
